sar_search: RTL and testbench



---
 rtl/sar_pkg.sv | 18 +
 rtl/sar_search.sv | 106 ++++++++++
 tb/tb_sar_search.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/sar_pkg.sv
// Shared types and helpers for the successive-approximation search controller.
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TEST = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 16;

  // True when exactly one comparator flag is asserted.
  function automatic logic onehot3(input logic gt, input logic eq, input logic lt);
    return (gt ^ eq ^ lt) & ~(gt & eq & lt);
  endfunction

endpackage

// File: rtl/sar_search.sv
// Successive-approximation search: drives comparator B, recovers hidden A MSB first.
module sar_search
  import sar_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             a_gt_b,
  input  logic             a_eq_b,
  input  logic             a_lt_b,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found,
  output logic             err
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               found_q, found_d;
  logic               err_q, err_d;
  logic [WIDTH-1:0]   trial_w;

  // Candidate bits are disjoint, so OR never carries.
  assign trial_w = acc_q | (WIDTH'(1) << idx_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      found_q  <= found_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    result_d = result_q;
    found_d  = found_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          idx_d   = IDX_W'(WIDTH - 1);
          found_d = 1'b0;
          err_d   = 1'b0;
          state_d = TEST;
        end
      end
      TEST: begin
        if (!onehot3(a_gt_b, a_eq_b, a_lt_b)) begin
          err_d    = 1'b1;
          found_d  = 1'b0;
          result_d = acc_q;
          state_d  = DONE;
        end else if (a_eq_b) begin
          result_d = trial_w;
          found_d  = 1'b1;
          state_d  = DONE;
        end else begin
          if (a_gt_b) acc_d = trial_w;
          if (idx_q == '0) begin
            result_d = a_gt_b ? trial_w : acc_q;
            found_d  = 1'b0;
            state_d  = DONE;
          end else begin
            idx_d = idx_q - IDX_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy   = (state_q == TEST);
  assign done   = (state_q == DONE);
  assign trial  = (state_q == TEST) ? trial_w : '0;
  assign result = result_q;
  assign found  = found_q;
  assign err    = err_q;

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search with a behavioural comparator and search model.
module tb_sar_search;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         a_gt_b, a_eq_b, a_lt_b;
  logic [W-1:0] trial, result;
  logic         busy, done, found, err;

  logic [W-1:0] a_val;
  logic         bad;
  logic [W-1:0] model_result;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Partner comparator; 'bad' forces an illegal gt+lt pattern.
  always_comb begin
    a_gt_b = bad ? 1'b1 : (a_val > trial);
    a_eq_b = bad ? 1'b0 : (a_val == trial);
    a_lt_b = bad ? 1'b1 : (a_val < trial);
  end

  sar_search #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a_gt_b (a_gt_b),
    .a_eq_b (a_eq_b),
    .a_lt_b (a_lt_b),
    .trial  (trial),
    .busy   (busy),
    .done   (done),
    .result (result),
    .found  (found),
    .err    (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Binary search over A: step n tests bit W-n on top of A's higher bits.
  task automatic run_search(input logic [W-1:0] a, input int fault_at, input bit poke_start);
    int           k;
    int           idx;
    logic [W-1:0] t;
    logic [W-1:0] exp_res;
    logic         exp_found;
    logic         exp_err;

    a_val = a;
    k = W;
    for (int b = W - 1; b >= 0; b--) if (a[b]) k = W - b;
    exp_res   = a;
    exp_found = (a != 0);
    exp_err   = 1'b0;
    if (fault_at > 0 && fault_at <= k) begin
      k         = fault_at;
      idx       = W - fault_at;
      exp_res   = W'((int'(a) >> (idx + 1)) << (idx + 1));
      exp_found = 1'b0;
      exp_err   = 1'b1;
    end

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("result_hold", result, model_result);
    for (int n = 1; n <= k; n++) begin
      idx = W - n;
      t = W'(((int'(a) >> (idx + 1)) << (idx + 1)) | (1 << idx));
      check("busy", busy, 1);
      check("trial", trial, t);
      check("done_early", done, 0);
      if (n == fault_at) bad = 1'b1;
      start = (poke_start && n == 2);
      @(negedge clk);
      bad = 1'b0;
    end
    start = 1'b0;
    check("done", done, 1);
    check("busy_in_done", busy, 0);
    check("trial_in_done", trial, 0);
    check("result", result, exp_res);
    check("found", found, exp_found);
    check("err", err, exp_err);
    model_result = exp_res;
    @(negedge clk);
    check("done_pulse", done, 0);
    check("busy_idle", busy, 0);
    check("result_stable", result, exp_res);
    check("found_stable", found, exp_found);
    check("err_stable", err, exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bad   = 1'b0;
    a_val = '0;
    model_result = '0;
    #1;
    check("rst_trial", trial, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_found", found, 0);
    check("rst_err", err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_search(8'hB5, 0, 1'b0);
    run_search(8'h80, 0, 1'b0);
    run_search(8'h00, 0, 1'b0);
    run_search(8'hFF, 0, 1'b0);
    run_search(8'hB5, 3, 1'b0);
    run_search(8'hB5, 0, 1'b1);
    run_search(8'h01, 0, 1'b0);

    // Asynchronous reset mid-search.
    a_val = 8'hB5;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_trial", trial, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_result", result, 0);
    check("arst_found", found, 0);
    check("arst_err", err, 0);
    @(posedge clk);
    #1;
    check("arst_no_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_result = '0;
    run_search(8'h3C, 0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      run_search(W'($urandom_range(0, 255)),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W)) : 0,
                 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
